coco_clk_seq: RTL and testbench
===============================

# coco_clk_seq

Clock-enable and reset sequencer for the 57.272727 MHz system clock (16× NTSC colour burst) produced by the core PLL. Waits for a stable PLL lock, then releases the core reset. Generates the single-cycle clock enables for the video path and the quadrature 6809 E/Q clocks. Any lock loss or soft-reset request pulls the core back into reset cleanly.

## Interface
- LOCK_WAIT, 1024: cycles `pll_locked` must stay high before the core reset is released.
- SOFT_RST_LEN, 16: `sys_reset` hold length, in cycles, for a soft reset.
- clk_sys  in  1  57.272727 MHz PLL output clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- pll_locked  in  1  PLL lock; asynchronous to `clk_sys`.
- soft_rst  in  1  level request for a core reset (e.g. from the OSD).
- turbo  in  1  double CPU rate; present only with COCO_TURBO_EN.
- sys_reset  out  1  active-high synchronous reset for the rest of the core.
- ready  out  1  high while in RUN.
- ce_pix  out  1  1-cycle pulse every 4 cycles (14.318 MHz).
- ce_vdg  out  1  1-cycle pulse every 16 cycles (3.58 MHz).
- cpu_e, cpu_q  out  1  E and Q level outputs (Q leads E by 90°).
- ce_e_rise, ce_e_fall, ce_q_rise, ce_q_fall  out  1  1-cycle pulses on the cycle the matching level changes.

## Operation
- `pll_locked` passes through a 2-FF synchronizer; `lk` is the synchronized value.
- States:
  - HOLD: entered on reset.
  - WAIT: counting stable lock.
  - RUN
  - SOFT: timed soft reset.
- Transitions:
  - HOLD→WAIT when `lk`=1.
  - WAIT: the lock counter increments while `lk`=1 and clears to 0 when `lk`=0. Go to RUN when the count reaches LOCK_WAIT−1.
  - RUN→WAIT when `lk`=0. This takes priority over `soft_rst`.
  - RUN→SOFT when `soft_rst`=1.
  - SOFT→WAIT when `lk`=0.
  - SOFT→RUN after SOFT_RST_LEN cycles, but only if `soft_rst` is low. If it is still high, stay in SOFT.
- `sys_reset`=1 in every state except RUN. `ready`=1 only in RUN.
- Video counter: 4 bits, cleared outside RUN, increments each RUN cycle.
  - `ce_pix` = (cnt[1:0]==3).
  - `ce_vdg` = (cnt==15).
- CPU phase counter: 6 bits, cleared outside RUN. Each RUN cycle it adds the step: 1 normally, 2 in turbo.
- E/Q decode on phase `p`:
  - `cpu_q` = p in [16,47].
  - `cpu_e` = p in [32,63].
- Edge pulses fire on the cycle the level changes:
  - ce_q_rise at p=16, ce_e_rise at p=32.
  - ce_q_fall at p=48, ce_e_fall on wrap to 0.
- Turbo latching: `turbo` is sampled only on the wrap to 0, so the E/Q duty never glitches mid-cycle.
- E rate: 57.27/64 = 0.895 MHz normal, 1.79 MHz turbo.
- All counters are 0 on RUN entry, so first-cycle behaviour is deterministic.

## Timing
- Reset values:
  - state=HOLD, all counters 0.
  - `sys_reset`=1, all other outputs 0.
- `pll_locked` to `lk` latency: 2 cycles.
- Lock rise to `sys_reset` falling: LOCK_WAIT+2 cycles (+1 for HOLD→WAIT).
- Lock loss to `sys_reset`=1: 3 cycles (sync plus state register). All enables stop the same cycle as `sys_reset` rises.
- First enables after RUN entry:
  - first `ce_pix` on RUN cycle 3, first `ce_vdg` on cycle 15.
  - first ce_q_rise on cycle 16 (normal) or cycle 8 (turbo, p=16).
- A lock glitch during WAIT restarts the full LOCK_WAIT count.
- `reset_n` asserted mid-RUN clears everything asynchronously. `sys_reset` goes high immediately, with no clock needed.
- All outputs are registered.

## Configuration
- COCO_TURBO_EN defined: the `turbo` port exists and the step is selected as described in Operation.
- COCO_TURBO_EN undefined: there is no `turbo` port, the step is fixed at 1, and the turbo latch is removed.

## Structure
- Package `coco_clk_pkg`:
  - state enum (HOLD, WAIT, RUN, SOFT).
  - phase constants: Q_RISE=16, E_RISE=32, Q_FALL=48.
  - VID_DIV=4, VDG_DIV=16.
- Sub-module `sync_2ff`: a reusable 2-flop level synchronizer with async active-low clear, used for `pll_locked`.

## Test plan
- `pll_locked` rises 10 cycles after `reset_n` deasserts, with LOCK_WAIT=8 → `sys_reset` falls 8+3 cycles after lock rises; no enables before then.
- RUN, normal mode, 256 cycles → 64 `ce_pix`, 16 `ce_vdg`, and 4 E periods of 64 cycles; Q rise precedes E rise by 16 cycles.
- `turbo` goes high at p=20 → the current E cycle keeps 64 cycles, then E periods become 32 cycles with a Q-to-E offset of 8.
- `pll_locked` drops for 1 cycle in RUN → `sys_reset`=1 after 3 cycles and all enables stop; the full LOCK_WAIT count is needed again.
- `soft_rst` pulse of 1 cycle → `sys_reset` high for 16 cycles; `soft_rst` held 40 cycles → `sys_reset` stays high until it drops.
- `reset_n` pulsed low mid-E-high → `cpu_e`=0 and `sys_reset`=1 asynchronously; state returns to HOLD.

Source files
------------

// File: rtl/coco_clk_pkg.sv
// Shared types and constants for the CoCo clock-enable / reset sequencer.
// Phase thresholds place Q a quarter cycle ahead of E on a 64-step phase wheel.
package coco_clk_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        WAIT = 2'd1,
        RUN  = 2'd2,
        SOFT = 2'd3
    } state_e;

    localparam int PH_W    = 6;
    localparam int VID_W   = 4;
    localparam int VID_DIV = 4;
    localparam int VDG_DIV = 16;

    localparam logic [PH_W-1:0] Q_RISE = 6'd16;
    localparam logic [PH_W-1:0] E_RISE = 6'd32;
    localparam logic [PH_W-1:0] Q_FALL = 6'd48;

    typedef struct packed {
        logic q;
        logic e;
    } eq_lvl_t;

    function automatic eq_lvl_t eq_decode(input logic [PH_W-1:0] p);
        eq_lvl_t lvl;
        lvl.q = (p >= Q_RISE) && (p < Q_FALL);
        lvl.e = (p >= E_RISE);
        return lvl;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Reusable two-flop level synchronizer with asynchronous active-low clear.
// Output is the input delayed by two clock edges; cleared value is 0.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // NOTE: sequential state uses non-blocking assignments so both flops sample
    // their inputs from before the edge; blocking here would collapse the chain.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/coco_clk_seq.sv
// Reset sequencer and clock-enable generator for the 57.27 MHz CoCo system clock.
// Optional feature: define COCO_TURBO_EN to add the turbo port (double CPU E/Q rate).
module coco_clk_seq
    import coco_clk_pkg::*;
#(
    parameter int LOCK_WAIT    = 1024,
    parameter int SOFT_RST_LEN = 16
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic pll_locked,
    input  logic soft_rst,
`ifdef COCO_TURBO_EN
    input  logic turbo,
`endif
    output logic sys_reset,
    output logic ready,
    output logic ce_pix,
    output logic ce_vdg,
    output logic cpu_e,
    output logic cpu_q,
    output logic ce_e_rise,
    output logic ce_e_fall,
    output logic ce_q_rise,
    output logic ce_q_fall
);

    localparam int CNT_TOP = (LOCK_WAIT > SOFT_RST_LEN) ? LOCK_WAIT : SOFT_RST_LEN;
    localparam int CNT_W   = (CNT_TOP > 1) ? $clog2(CNT_TOP) : 1;
    localparam int PIX_B   = $clog2(VID_DIV);

    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_WAIT - 1);
    localparam logic [CNT_W-1:0] SOFT_LAST = CNT_W'(SOFT_RST_LEN - 1);

    logic w_lk;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .i_clk   (clk_sys),
        .i_rst_n (reset_n),
        .i_d     (pll_locked),
        .o_q     (w_lk)
    );

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_sys_reset;
    logic             r_ready;

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            HOLD: begin
                w_cnt_nxt = '0;
                if (w_lk) w_state_nxt = WAIT;
            end
            WAIT: begin
                if (!w_lk) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == LOCK_LAST) begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            RUN: begin
                w_cnt_nxt = '0;
                if (!w_lk)         w_state_nxt = WAIT;
                else if (soft_rst) w_state_nxt = SOFT;
            end
            SOFT: begin
                if (!w_lk) begin
                    w_state_nxt = WAIT;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == SOFT_LAST) begin
                    // Saturate here until the request is withdrawn.
                    if (!soft_rst) begin
                        w_state_nxt = RUN;
                        w_cnt_nxt   = '0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = HOLD;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= HOLD;
            r_cnt       <= '0;
            r_sys_reset <= 1'b1;
            r_ready     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_sys_reset <= (w_state_nxt != RUN);
            r_ready     <= (w_state_nxt == RUN);
        end
    end

    // Counters advance only while staying in RUN, so they read 0 on the first RUN cycle.
    logic             w_adv;
    logic [VID_W-1:0] r_vcnt;
    logic [VID_W-1:0] w_vcnt_nxt;
    logic [PH_W-1:0]  r_ph;
    logic [PH_W-1:0]  w_ph_nxt;
    logic [PH_W-1:0]  w_step;
    logic             w_wrap;
    eq_lvl_t          w_lvl_nxt;

    assign w_adv      = (r_state == RUN) && (w_state_nxt == RUN);
    assign w_vcnt_nxt = w_adv ? r_vcnt + VID_W'(1) : '0;
    assign w_ph_nxt   = w_adv ? r_ph + w_step : '0;
    assign w_wrap     = w_adv && (w_ph_nxt == '0);
    assign w_lvl_nxt  = eq_decode(w_ph_nxt);

`ifdef COCO_TURBO_EN
    logic r_turbo;

    // Rate changes only where the phase is 0, so an E/Q cycle is never cut short.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)             r_turbo <= 1'b0;
        else if (w_ph_nxt == '0)  r_turbo <= turbo;
    end

    assign w_step = r_turbo ? PH_W'(2) : PH_W'(1);
`else
    assign w_step = PH_W'(1);
`endif

    logic r_ce_pix;
    logic r_ce_vdg;
    logic r_cpu_e;
    logic r_cpu_q;
    logic r_ce_e_rise;
    logic r_ce_e_fall;
    logic r_ce_q_rise;
    logic r_ce_q_fall;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_vcnt      <= '0;
            r_ph        <= '0;
            r_ce_pix    <= 1'b0;
            r_ce_vdg    <= 1'b0;
            r_cpu_e     <= 1'b0;
            r_cpu_q     <= 1'b0;
            r_ce_e_rise <= 1'b0;
            r_ce_e_fall <= 1'b0;
            r_ce_q_rise <= 1'b0;
            r_ce_q_fall <= 1'b0;
        end else begin
            r_vcnt      <= w_vcnt_nxt;
            r_ph        <= w_ph_nxt;
            r_ce_pix    <= w_adv && (w_vcnt_nxt[PIX_B-1:0] == PIX_B'(VID_DIV - 1));
            r_ce_vdg    <= w_adv && (w_vcnt_nxt == VID_W'(VDG_DIV - 1));
            r_cpu_e     <= w_adv && w_lvl_nxt.e;
            r_cpu_q     <= w_adv && w_lvl_nxt.q;
            r_ce_e_rise <= w_adv && (w_ph_nxt == E_RISE);
            r_ce_e_fall <= w_wrap;
            r_ce_q_rise <= w_adv && (w_ph_nxt == Q_RISE);
            r_ce_q_fall <= w_adv && (w_ph_nxt == Q_FALL);
        end
    end

    assign sys_reset = r_sys_reset;
    assign ready     = r_ready;
    assign ce_pix    = r_ce_pix;
    assign ce_vdg    = r_ce_vdg;
    assign cpu_e     = r_cpu_e;
    assign cpu_q     = r_cpu_q;
    assign ce_e_rise = r_ce_e_rise;
    assign ce_e_fall = r_ce_e_fall;
    assign ce_q_rise = r_ce_q_rise;
    assign ce_q_fall = r_ce_q_fall;

endmodule

// File: tb/tb_coco_clk_seq.sv
// Directed bench for coco_clk_seq with LOCK_WAIT=8; turbo cases need COCO_TURBO_EN.
// Expected cycle numbers are hand-derived from the sequencer timing.
module tb_coco_clk_seq;

    logic clk_sys    = 1'b0;
    logic reset_n    = 1'b0;
    logic pll_locked = 1'b0;
    logic soft_rst   = 1'b0;
`ifdef COCO_TURBO_EN
    logic turbo      = 1'b0;
`endif
    logic sys_reset, ready, ce_pix, ce_vdg, cpu_e, cpu_q;
    logic ce_e_rise, ce_e_fall, ce_q_rise, ce_q_fall;

    coco_clk_seq #(
        .LOCK_WAIT    (8),
        .SOFT_RST_LEN (16)
    ) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .pll_locked (pll_locked),
        .soft_rst   (soft_rst),
`ifdef COCO_TURBO_EN
        .turbo      (turbo),
`endif
        .sys_reset  (sys_reset),
        .ready      (ready),
        .ce_pix     (ce_pix),
        .ce_vdg     (ce_vdg),
        .cpu_e      (cpu_e),
        .cpu_q      (cpu_q),
        .ce_e_rise  (ce_e_rise),
        .ce_e_fall  (ce_e_fall),
        .ce_q_rise  (ce_q_rise),
        .ce_q_fall  (ce_q_fall)
    );

    always #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc;
    int q_pix[$], q_vdg[$], q_qr[$], q_er[$], q_ef[$];
    int n_e_hi, n_q_hi;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic logic any_out();
        return ready | ce_pix | ce_vdg | cpu_e | cpu_q |
               ce_e_rise | ce_e_fall | ce_q_rise | ce_q_fall;
    endfunction

    task automatic record();
        if (ce_pix)    q_pix.push_back(cyc);
        if (ce_vdg)    q_vdg.push_back(cyc);
        if (ce_q_rise) q_qr.push_back(cyc);
        if (ce_e_rise) q_er.push_back(cyc);
        if (ce_e_fall) q_ef.push_back(cyc);
        if (cpu_e)     n_e_hi++;
        if (cpu_q)     n_q_hi++;
    endtask

    task automatic clear_log();
        q_pix.delete(); q_vdg.delete(); q_qr.delete(); q_er.delete(); q_ef.delete();
        n_e_hi = 0;
        n_q_hi = 0;
    endtask

    task automatic run_n(input int n);
        repeat (n) begin
            @(negedge clk_sys);
            record();
            cyc++;
        end
    endtask

    // Called on the sample where sys_reset has just fallen (RUN cycle 0).
    task automatic start_run();
        clear_log();
        cyc = 0;
        record();
        cyc = 1;
    endtask

    // Samples each negedge up to n times; stops on the sample where sys_reset falls.
    task automatic watch(input int n, input int lock_until, input int soft_until,
                         output int t_rise, output int t_fall, output int leak);
        t_rise = -1;
        t_fall = -1;
        leak   = 0;
        for (int i = 1; i <= n && t_fall < 0; i++) begin
            @(negedge clk_sys);
            if (sys_reset && t_rise < 0)   t_rise = i;
            if (!sys_reset && t_rise >= 0) t_fall = i;
            if (sys_reset && any_out())    leak = 1;
            if (i == lock_until) pll_locked = 1'b1;
            if (i == soft_until) soft_rst   = 1'b0;
        end
    endtask

    initial begin
        int tr, tf, lk;

        repeat (3) @(negedge clk_sys);
        check("reset_outputs",
              {sys_reset, ready, ce_pix, ce_vdg, cpu_e, cpu_q,
               ce_e_rise, ce_e_fall, ce_q_rise, ce_q_fall}, 10'b10_0000_0000);

        reset_n = 1'b1;
        repeat (10) @(negedge clk_sys);
        check("hold_without_lock", sys_reset, 1);

        pll_locked = 1'b1;
        watch(40, 0, 0, tr, tf, lk);
        check("lock_to_run_cycles", tf, 11);
        check("no_enable_before_run", lk, 0);

        start_run();
        run_n(255);
        check("pix_count_256", q_pix.size(), 64);
        check("first_pix_cycle", q_pix[0], 3);
        check("vdg_count_256", q_vdg.size(), 16);
        check("first_vdg_cycle", q_vdg[0], 15);
        check("e_rise_count", q_er.size(), 4);
        check("e_period_a", q_er[1] - q_er[0], 64);
        check("e_period_b", q_er[3] - q_er[2], 64);
        check("first_q_rise", q_qr[0], 16);
        check("q_leads_e", q_er[0] - q_qr[0], 16);
        check("e_fall_count", q_ef.size(), 3);
        check("first_e_fall", q_ef[0], 64);
        check("e_high_cycles", n_e_hi, 128);
        check("q_high_cycles", n_q_hi, 128);

        clear_log();
        run_n(21);
`ifdef COCO_TURBO_EN
        turbo = 1'b1;
`endif
        run_n(124);
        check("e_fall_at_256", q_ef[0], 256);
        check("e_cycle_kept_64", q_ef[1] - q_ef[0], 64);
`ifdef COCO_TURBO_EN
        check("turbo_e_period_fall", q_ef[2] - q_ef[1], 32);
        check("turbo_e_period_fall2", q_ef[3] - q_ef[2], 32);
        check("turbo_q_to_e", q_er[1] - q_qr[1], 8);
        check("turbo_e_period_rise", q_er[2] - q_er[1], 32);
        turbo = 1'b0;
`else
        check("normal_e_period_fall", q_ef[2] - q_ef[1], 64);
        check("normal_q_to_e", q_er[1] - q_qr[1], 16);
        check("normal_e_fall_count", q_ef.size(), 3);
`endif

        pll_locked = 1'b0;
        watch(40, 1, 0, tr, tf, lk);
        check("lockloss_reset_rise", tr, 3);
        check("lockloss_relock_run", tf, 11);
        check("lockloss_enables_off", lk, 0);

        start_run();
        run_n(20);
        check("rerun_first_pix", q_pix[0], 3);
        check("rerun_first_q_rise", q_qr[0], 16);

        soft_rst = 1'b1;
        watch(40, 0, 1, tr, tf, lk);
        check("soft_pulse_rise", tr, 1);
        check("soft_pulse_len", tf - tr, 16);
        check("soft_enables_off", lk, 0);

        soft_rst = 1'b1;
        watch(80, 0, 40, tr, tf, lk);
        check("soft_held_rise", tr, 1);
        check("soft_held_release", tf, 41);

        start_run();
        run_n(40);
        check("e_high_before_rst", cpu_e, 1);
        reset_n = 1'b0;
        #1;
        check("async_rst_cpu_e", cpu_e, 0);
        check("async_rst_sys_reset", sys_reset, 1);
        check("async_rst_ready", ready, 0);
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;
        watch(40, 0, 0, tr, tf, lk);
        check("post_rst_from_hold", tf, 11);
        check("post_rst_enables_off", lk, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
